// File: rtl/paddle_motion_ctrl.sv
// ============================================================================
// paddle_motion_ctrl: per-frame right-paddle position update and ball/paddle
// collision pulse generation.
// Rev 1.0
// ============================================================================
`default_nettype none

module paddle_motion_ctrl #(
  parameter logic [7:0] PADDLE_X  = 8'd150,
  parameter int         PADDLE_H  = 8,
  parameter logic [6:0] Y_RESET   = 7'd56,
  parameter logic [6:0] Y_MAX     = 7'd119,
  parameter int         SLOW_DIV  = 2,
  parameter int         FAST_STEP = 2
) (
  input  logic       clock,
  input  logic       reset,
  input  logic       frame_tick,
  input  logic       go_r,
  input  logic       speed_r,
  input  logic       up_r,
  input  logic       down_r,
  input  logic       recentre,
  input  logic [7:0] ball_x,
  input  logic [6:0] ball_y,
  input  logic [7:0] ball_dx,
  output logic [6:0] y_rp,
  output logic       paddle_hit,
  output logic       paddle_miss,
  output logic       busy
);

  localparam logic [1:0] S_WAIT = 2'd0;
  localparam logic [1:0] S_MOVE = 2'd1;
  localparam logic [1:0] S_HIT  = 2'd2;

  localparam int             DIV_W    = (SLOW_DIV > 2) ? $clog2(SLOW_DIV) : 1;
  localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(SLOW_DIV - 1);
  localparam logic [7:0]     Y_LIMIT  = {1'b0, Y_MAX} - 8'(PADDLE_H) + 8'd1;
  localparam logic [7:0]     HIT_COL  = PADDLE_X - 8'd1;

  logic [1:0]       state;
  logic [1:0]       state_nxt;
  logic [DIV_W-1:0] div_cnt;
  logic [DIV_W-1:0] div_nxt;
  logic [6:0]       y_nxt;
  logic [7:0]       step;
  logic [7:0]       y_ext;
  logic [7:0]       y_sum;
  logic [7:0]       span_bot;
  logic             in_column;
  logic             on_paddle;

  always_ff @(posedge clock or posedge reset) begin
    if (reset) state <= S_WAIT;
    else       state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      S_WAIT:  if (frame_tick) state_nxt = S_MOVE;
      S_MOVE:  state_nxt = S_HIT;
      S_HIT:   state_nxt = S_WAIT;
      default: state_nxt = S_WAIT;
    endcase
  end

  always_comb begin
    busy = (state == S_MOVE) || (state == S_HIT);
  end

  // 8-bit intermediates keep the up/down arithmetic from wrapping at 7 bits
  always_comb begin
    step    = 8'd0;
    div_nxt = div_cnt;
    y_nxt   = y_rp;
    y_ext   = {1'b0, y_rp};
    y_sum   = 8'd0;
    if (recentre) begin
      y_nxt   = Y_RESET;
      div_nxt = '0;
    end else if (go_r && (up_r != down_r)) begin
      if (speed_r) begin
        step    = 8'(FAST_STEP);
        div_nxt = '0;
      end else if (div_cnt == DIV_LAST) begin
        step    = 8'd1;
        div_nxt = '0;
      end else begin
        div_nxt = div_cnt + 1'b1;
      end
      y_sum = y_ext + step;
      if (up_r) y_nxt = (y_ext < step) ? 7'd0 : 7'(y_ext - step);
      else      y_nxt = (y_sum > Y_LIMIT) ? Y_LIMIT[6:0] : y_sum[6:0];
    end
  end

  always_comb begin
    span_bot  = {1'b0, y_rp} + 8'(PADDLE_H - 1);
    in_column = (ball_dx <= 8'h7F) && (ball_x == HIT_COL);
    on_paddle = (ball_y >= y_rp) && ({1'b0, ball_y} <= span_bot);
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      y_rp        <= Y_RESET;
      div_cnt     <= '0;
      paddle_hit  <= 1'b0;
      paddle_miss <= 1'b0;
    end else begin
      paddle_hit  <= 1'b0;
      paddle_miss <= 1'b0;
      if (state == S_MOVE) begin
        y_rp    <= y_nxt;
        div_cnt <= div_nxt;
      end
      if (state == S_HIT) begin
        paddle_hit  <= in_column && on_paddle;
        paddle_miss <= in_column && !on_paddle;
      end
    end
  end

endmodule

`default_nettype wire

// File: tb/tb_paddle_motion_ctrl.sv
// ============================================================================
// tb_paddle_motion_ctrl: directed scoreboard bench for paddle_motion_ctrl.
// Rev 1.0
// ============================================================================
`default_nettype none

module tb_paddle_motion_ctrl;

  logic       clock = 1'b0;
  logic       reset = 1'b1;
  logic       frame_tick = 1'b0;
  logic       go_r = 1'b0;
  logic       speed_r = 1'b0;
  logic       up_r = 1'b0;
  logic       down_r = 1'b0;
  logic       recentre = 1'b0;
  logic [7:0] ball_x = 8'd0;
  logic [6:0] ball_y = 7'd0;
  logic [7:0] ball_dx = 8'd0;
  logic [6:0] y_rp;
  logic       paddle_hit;
  logic       paddle_miss;
  logic       busy;

  paddle_motion_ctrl dut (
    .clock(clock), .reset(reset), .frame_tick(frame_tick), .go_r(go_r),
    .speed_r(speed_r), .up_r(up_r), .down_r(down_r), .recentre(recentre),
    .ball_x(ball_x), .ball_y(ball_y), .ball_dx(ball_dx), .y_rp(y_rp),
    .paddle_hit(paddle_hit), .paddle_miss(paddle_miss), .busy(busy)
  );

  always #10 clock = ~clock;

  typedef struct packed {
    logic [6:0] y;
    logic       hit;
    logic       miss;
  } exp_t;

  exp_t sb[$];
  int   n_vec = 0;
  int   n_err = 0;
  int   m_y   = 56;
  int   m_div = 0;
  logic obs_hit, obs_miss;

  task automatic check(input string tag, input int obs, input int exp);
    n_vec++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  // Reference behaviour of one S_MOVE update on the model state
  task automatic model_step();
    int st;
    st = 0;
    if (recentre) begin
      m_y = 56; m_div = 0;
    end else if (go_r && (up_r != down_r)) begin
      if (speed_r) begin
        st = 2; m_div = 0;
      end else if (m_div == 1) begin
        st = 1; m_div = 0;
      end else begin
        m_div = m_div + 1;
      end
      if (up_r) m_y = (m_y < st) ? 0 : m_y - st;
      else      m_y = (m_y + st > 112) ? 112 : m_y + st;
    end
  endtask

  task automatic frame(input logic go, input logic spd, input logic up, input logic dn,
                       input logic rec, input logic [7:0] bx, input logic [6:0] by,
                       input logic [7:0] bdx, input string tag);
    exp_t e;
    logic col, on;
    @(negedge clock);
    go_r = go; speed_r = spd; up_r = up; down_r = dn; recentre = rec;
    ball_x = bx; ball_y = by; ball_dx = bdx;
    frame_tick = 1'b1;
    model_step();
    col = (bdx <= 8'h7F) && (bx == 8'd149);
    on  = (int'(by) >= m_y) && (int'(by) <= m_y + 7);
    e.y = 7'(m_y); e.hit = col && on; e.miss = col && !on;
    sb.push_back(e);
    @(negedge clock);
    frame_tick = 1'b0;
    check({tag, "_busy_move"}, int'(busy), 1);
    @(negedge clock);
    check({tag, "_y"}, int'(y_rp), int'(sb[0].y));
    check({tag, "_pre_hit"}, int'(paddle_hit), 0);
    @(negedge clock);
    e = sb.pop_front();
    obs_hit = paddle_hit; obs_miss = paddle_miss;
    check({tag, "_hit"}, int'(paddle_hit), int'(e.hit));
    check({tag, "_miss"}, int'(paddle_miss), int'(e.miss));
    check({tag, "_busy_idle"}, int'(busy), 0);
    @(negedge clock);
    check({tag, "_hit_end"}, int'(paddle_hit), 0);
    check({tag, "_miss_end"}, int'(paddle_miss), 0);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog timeout");
    $fatal(1, "watchdog");
  end

  initial begin
    int seq3[6];
    seq3 = '{110, 111, 111, 112, 112, 112};

    // 1: reset state, move to 90, reset returns to 56
    repeat (2) @(negedge clock);
    reset = 1'b0;
    @(negedge clock);
    check("rst_y", int'(y_rp), 56);
    check("rst_hit", int'(paddle_hit), 0);
    check("rst_miss", int'(paddle_miss), 0);
    check("rst_busy", int'(busy), 0);
    repeat (17) frame(1, 1, 0, 1, 0, 8'd0, 7'd0, 8'd1, "to90");
    check("at90", int'(y_rp), 90);
    @(negedge clock);
    reset = 1'b1;
    #1;
    check("rst90_y", int'(y_rp), 56);
    @(negedge clock);
    reset = 1'b0;
    m_y = 56; m_div = 0;

    // 2: fast up to 0 without wrapping
    repeat (26) frame(1, 1, 1, 0, 0, 8'd0, 7'd0, 8'd1, "to4");
    repeat (2) frame(1, 0, 1, 0, 0, 8'd0, 7'd0, 8'd1, "to3");
    check("at3", int'(y_rp), 3);
    frame(1, 1, 1, 0, 0, 8'd0, 7'd0, 8'd1, "up1");
    check("up_to1", int'(y_rp), 1);
    frame(1, 1, 1, 0, 0, 8'd0, 7'd0, 8'd1, "up0");
    check("up_to0", int'(y_rp), 0);
    frame(1, 1, 1, 0, 0, 8'd0, 7'd0, 8'd1, "upclamp");
    check("up_nowrap", int'(y_rp), 0);

    // 3: slow down with clamp at 112
    repeat (55) frame(1, 1, 0, 1, 0, 8'd0, 7'd0, 8'd1, "to110");
    check("at110", int'(y_rp), 110);
    for (int i = 0; i < 6; i++) begin
      frame(1, 0, 0, 1, 0, 8'd0, 7'd0, 8'd1, "slowdn");
      check("slowdn_seq", int'(y_rp), seq3[i]);
    end

    // 4: hold conditions and recentre
    frame(1, 0, 0, 1, 1, 8'd0, 7'd0, 8'd1, "rec112");
    check("rec_from112", int'(y_rp), 56);
    for (int i = 0; i < 4; i++) begin
      frame(1, 1, 1, 1, 0, 8'd0, 7'd0, 8'd1, "updn");
      check("updn_hold", int'(y_rp), 56);
    end
    for (int i = 0; i < 4; i++) begin
      frame(0, 1, 0, 1, 0, 8'd0, 7'd0, 8'd1, "nogo");
      check("nogo_hold", int'(y_rp), 56);
    end
    repeat (12) frame(1, 1, 0, 1, 0, 8'd0, 7'd0, 8'd1, "to80");
    check("at80", int'(y_rp), 80);
    frame(1, 1, 0, 1, 1, 8'd0, 7'd0, 8'd1, "rec80");
    check("rec_from80", int'(y_rp), 56);

    // 5: collision boundaries at y_rp=56
    frame(0, 0, 0, 0, 0, 8'd149, 7'd63, 8'd1, "hit63");
    check("hit63_pulse", int'(obs_hit), 1);
    frame(0, 0, 0, 0, 0, 8'd149, 7'd56, 8'd1, "hit56");
    check("hit56_pulse", int'(obs_hit), 1);
    frame(0, 0, 0, 0, 0, 8'd149, 7'd64, 8'd1, "miss64");
    check("miss64_pulse", int'(obs_miss), 1);
    frame(0, 0, 0, 0, 0, 8'd149, 7'd55, 8'd1, "miss55");
    check("miss55_pulse", int'(obs_miss), 1);
    frame(0, 0, 0, 0, 0, 8'd149, 7'd60, 8'hFF, "left");
    check("left_none", int'(obs_hit | obs_miss), 0);
    frame(0, 0, 0, 0, 0, 8'd149, 7'd60, 8'h7F, "dx7f");
    check("dx7f_hit", int'(obs_hit), 1);
    frame(0, 0, 0, 0, 0, 8'd150, 7'd60, 8'd1, "col150");
    check("col150_none", int'(obs_hit | obs_miss), 0);

    // 6: back-to-back ticks give one update
    @(negedge clock);
    go_r = 1; speed_r = 1; up_r = 0; down_r = 1; recentre = 0;
    ball_x = 8'd0; frame_tick = 1'b1;
    @(negedge clock);
    @(negedge clock);
    frame_tick = 1'b0;
    check("dbl_y1", int'(y_rp), 58);
    repeat (4) @(negedge clock);
    check("dbl_y_final", int'(y_rp), 58);
    check("dbl_busy", int'(busy), 0);

    // 6: reset in S_MOVE aborts the update and suppresses the pulse
    @(negedge clock);
    ball_x = 8'd149; ball_y = 7'd60; ball_dx = 8'd1;
    frame_tick = 1'b1;
    @(negedge clock);
    frame_tick = 1'b0;
    check("abort_busy_pre", int'(busy), 1);
    reset = 1'b1;
    #1;
    check("abort_y", int'(y_rp), 56);
    check("abort_busy", int'(busy), 0);
    @(negedge clock);
    reset = 1'b0;
    for (int i = 0; i < 3; i++) begin
      @(negedge clock);
      check("abort_nohit", int'(paddle_hit | paddle_miss), 0);
      check("abort_y_hold", int'(y_rp), 56);
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

`default_nettype wire
